psram_rd_fifo_wr_ctrl: RTL and testbench

//  Write-side controller for the 16x18 pSRAM read-data FIFO RAM. Sits between the pSRAM IO

---
 rtl/psram_rd_pkg.sv | 32 +++
 rtl/psram_rd_fifo_wr_ctrl_wptr.sv | 42 ++++
 rtl/psram_rd_fifo_wr_ctrl.sv | 171 +++++++++++++++++
 tb/tb_psram_rd_fifo_wr_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_rd_pkg.sv
// Shared types, widths and Gray-code helpers for the pSRAM read-data FIFOs.
package psram_rd_pkg;

  localparam int AW   = 4;             // FIFO address width, depth 16
  localparam int BW   = 9;             // read beat width
  localparam int DW   = 2 * BW;        // FIFO word width
  localparam int LENW = 8;             // burst length field width (words)
  localparam int TMO  = 64;            // beatless cycles tolerated inside a burst
  localparam int PW   = AW + 1;        // pointer width incl. wrap bit
  localparam int TMOW = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CAPT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } state_e;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/psram_rd_fifo_wr_ctrl_wptr.sv
// Write pointer for a pSRAM FIFO: binary count, registered Gray copy for the
// read clock domain, and full detection against the synchronised read pointer.
module fifo_wptr_gray
  import psram_rd_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  input  logic [PW-1:0] rptr_gray_i,
  output logic [AW-1:0] waddr_o,
  output logic [PW-1:0] wptr_gray_o,
  output logic          full_o
);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] wgray_q;
  logic [PW-1:0] rptr_bin;

  assign wptr_d = wptr_q + PW'(inc_i);

  // Binary pointer and its Gray image advance on the same edge, so the Gray
  // value never carries a multi-bit transition into the other domain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      wgray_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      wgray_q <= bin2gray(wptr_d);
    end
  end

  // Full when the pointers sit on the same slot but one lap apart.
  always_comb begin
    rptr_bin = gray2bin(rptr_gray_i);
    full_o   = (wptr_q[AW] != rptr_bin[AW]) && (wptr_q[AW-1:0] == rptr_bin[AW-1:0]);
  end

  assign waddr_o     = wptr_q[AW-1:0];
  assign wptr_gray_o = wgray_q;

endmodule

// File: rtl/psram_rd_fifo_wr_ctrl.sv
// Write-side controller of the pSRAM read-data FIFO: packs pairs of 9-bit
// read beats into 18-bit words and writes them into the 16x18 FIFO RAM.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | waiting for a burst command, cmd_rdy high
//   ST_CAPT  | collecting beats, writing words, watching for timeout
//   ST_DONE  | one cycle, burst completed: done=1 err=0
//   ST_ABORT | one cycle, burst timed out: done=1 err=1
module psram_rd_fifo_wr_ctrl
  import psram_rd_pkg::*;
(
  input  logic            clkw,
  input  logic            rstnw,
  input  logic            cmd_vld,
  input  logic [LENW-1:0] cmd_len,
  output logic            cmd_rdy,
  input  logic            beat_vld,
  input  logic [BW-1:0]   beat_data,
  input  logic [AW:0]     rptr_gray,
  output logic            cew,
  output logic [AW-1:0]   aw,
  output logic [DW-1:0]   dw,
  output logic [AW:0]     wptr_gray,
  output logic            full,
  output logic            done,
  output logic            err,
  output logic            ovf,
  output logic            stray,
  input  logic            flag_clr
);

  state_e            state_q, state_d;
  logic              half_q, half_d;
  logic [BW-1:0]     hold_q, hold_d;
  logic [LENW-1:0]   wcnt_q, wcnt_d;
  logic [TMOW-1:0]   tmo_q, tmo_d;
  logic              cew_q, cew_d;
  logic [DW-1:0]     dw_q, dw_d;
  logic              ovf_q, ovf_d;
  logic              stray_q, stray_d;

  logic              in_idle;
  logic              in_capt;
  logic              accept;
  logic              word_done;
  logic              last_word;
  logic              tmo_hit;

  assign in_idle   = (state_q == ST_IDLE);
  assign in_capt   = (state_q == ST_CAPT);
  assign accept    = in_idle && cmd_vld && (cmd_len != '0);
  assign word_done = in_capt && beat_vld && half_q;
  // A dropped word still counts toward the burst, so the last word ends the
  // burst whether or not it reached the RAM.
  assign last_word = word_done && (wcnt_q == LENW'(1));
  assign tmo_hit   = in_capt && (tmo_q == TMOW'(TMO));

  // State register.
  always_ff @(posedge clkw) begin
    if (rstnw) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_CAPT;
      ST_CAPT: begin
        if (last_word)    state_d = ST_DONE;
        else if (tmo_hit) state_d = ST_ABORT;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    cmd_rdy = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    case (state_q)
      ST_IDLE:  cmd_rdy = 1'b1;
      ST_DONE:  done    = 1'b1;
      ST_ABORT: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

  // Beat packing, word/timeout counters, RAM write strobe and sticky flags.
  always_comb begin
    half_d  = half_q;
    hold_d  = hold_q;
    wcnt_d  = wcnt_q;
    tmo_d   = tmo_q;
    cew_d   = 1'b0;
    dw_d    = dw_q;

    if (in_capt) begin
      if (beat_vld) begin
        half_d = ~half_q;
        tmo_d  = '0;
        if (!half_q) hold_d = beat_data;
      end else if (tmo_q != TMOW'(TMO)) begin
        tmo_d = tmo_q + TMOW'(1);
      end
      if (word_done) begin
        wcnt_d = wcnt_q - LENW'(1);
        if (!full) begin
          cew_d = 1'b1;
          dw_d  = {beat_data, hold_q};
        end
      end
    end else begin
      // Outside a burst any half-collected word is discarded.
      half_d = 1'b0;
      tmo_d  = '0;
      if (accept) wcnt_d = cmd_len;
    end

    // Set events take priority over a simultaneous clear.
    ovf_d   = (word_done && full) || (ovf_q && !flag_clr);
    stray_d = (beat_vld && !in_capt) || (stray_q && !flag_clr);
  end

  // Datapath registers.
  always_ff @(posedge clkw) begin
    if (rstnw) begin
      half_q  <= 1'b0;
      hold_q  <= '0;
      wcnt_q  <= '0;
      tmo_q   <= '0;
      cew_q   <= 1'b0;
      dw_q    <= '0;
      ovf_q   <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      half_q  <= half_d;
      hold_q  <= hold_d;
      wcnt_q  <= wcnt_d;
      tmo_q   <= tmo_d;
      cew_q   <= cew_d;
      dw_q    <= dw_d;
      ovf_q   <= ovf_d;
      stray_q <= stray_d;
    end
  end

  // The pointer advances at the end of the cycle that carries the write.
  fifo_wptr_gray u_wptr (
    .clk_i       (clkw),
    .rst_i       (rstnw),
    .inc_i       (cew_q),
    .rptr_gray_i (rptr_gray),
    .waddr_o     (aw),
    .wptr_gray_o (wptr_gray),
    .full_o      (full)
  );

  assign cew   = cew_q;
  assign dw    = dw_q;
  assign ovf   = ovf_q;
  assign stray = stray_q;

endmodule

// File: tb/tb_psram_rd_fifo_wr_ctrl.sv
// Directed bench for the pSRAM read FIFO write controller.
module tb_psram_rd_fifo_wr_ctrl;

  logic        clkw = 1'b0;
  logic        rstnw = 1'b1;
  logic        cmd_vld = 1'b0;
  logic [7:0]  cmd_len = 8'd0;
  logic        cmd_rdy;
  logic        beat_vld = 1'b0;
  logic [8:0]  beat_data = 9'd0;
  logic [4:0]  rptr_gray = 5'd0;
  logic        cew;
  logic [3:0]  aw;
  logic [17:0] dw;
  logic [4:0]  wptr_gray;
  logic        full;
  logic        done;
  logic        err;
  logic        ovf;
  logic        stray;
  logic        flag_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [3:0]  aw_log[$];
  logic [17:0] dw_log[$];
  int          done_cnt = 0;
  int          full_cnt = 0;
  logic        last_err = 1'b0;

  psram_rd_fifo_wr_ctrl dut (
    .clkw      (clkw),
    .rstnw     (rstnw),
    .cmd_vld   (cmd_vld),
    .cmd_len   (cmd_len),
    .cmd_rdy   (cmd_rdy),
    .beat_vld  (beat_vld),
    .beat_data (beat_data),
    .rptr_gray (rptr_gray),
    .cew       (cew),
    .aw        (aw),
    .dw        (dw),
    .wptr_gray (wptr_gray),
    .full      (full),
    .done      (done),
    .err       (err),
    .ovf       (ovf),
    .stray     (stray),
    .flag_clr  (flag_clr)
  );

  always #5 clkw = ~clkw;

  // Record RAM writes, done pulses and full cycles mid-way between edges.
  always @(negedge clkw) begin
    if (cew) begin
      aw_log.push_back(aw);
      dw_log.push_back(dw);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      last_err = err;
    end
    if (full) full_cnt = full_cnt + 1;
  end

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] x;
    x = b[4:0];
    return x ^ (x >> 1);
  endfunction

  function automatic logic [31:0] aw_at(input int i);
    return (i < aw_log.size()) ? {28'd0, aw_log[i]} : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] dw_at(input int i);
    return (i < dw_log.size()) ? {14'd0, dw_log[i]} : 32'hFFFF_FFFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clkw);
    #1;
  endtask

  task automatic do_reset();
    rstnw = 1'b1;
    step();
    step();
    rstnw = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] len);
    cmd_vld = 1'b1;
    cmd_len = len;
    step();
    cmd_vld = 1'b0;
    cmd_len = 8'd0;
  endtask

  task automatic send_beats(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      beat_vld  = 1'b1;
      beat_data = 9'(first + i);
      step();
    end
    beat_vld = 1'b0;
  endtask

  int wb, db, fb;

  initial begin
    // ---- reset state
    step();
    step();
    rstnw = 1'b0;
    chk("rst_cmd_rdy", cmd_rdy, 1);
    chk("rst_cew", cew, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_stray", stray, 0);
    chk("rst_full", full, 0);
    chk("rst_wptr_gray", wptr_gray, 0);
    chk("rst_aw", aw, 0);
    chk("rst_dw", dw, 0);

    // ---- 1: four-word burst, back-to-back beats
    wb = aw_log.size(); db = done_cnt;
    send_cmd(8'd4);
    chk("t1_cmd_rdy_busy", cmd_rdy, 0);
    send_beats(1, 8);
    step(); step(); step();
    chk("t1_nwrites", aw_log.size() - wb, 4);
    chk("t1_dw0", dw_at(wb + 0), 32'h0401);
    chk("t1_dw1", dw_at(wb + 1), 32'h0803);
    chk("t1_dw2", dw_at(wb + 2), 32'h0C05);
    chk("t1_dw3", dw_at(wb + 3), 32'h1007);
    for (int i = 0; i < 4; i++) chk("t1_aw", aw_at(wb + i), i);
    chk("t1_done", done_cnt - db, 1);
    chk("t1_err", last_err, 0);
    chk("t1_wptr_gray", wptr_gray, 5'b00110);
    chk("t1_cmd_rdy", cmd_rdy, 1);

    // ---- 2: overflow with reader stalled at 0
    do_reset();
    rptr_gray = 5'd0;
    wb = aw_log.size(); db = done_cnt;
    send_cmd(8'd20);
    send_beats(16, 40);
    step(); step(); step();
    chk("t2_nwrites", aw_log.size() - wb, 16);
    chk("t2_dw0", dw_at(wb), 32'h2210);
    chk("t2_aw15", aw_at(wb + 15), 15);
    chk("t2_full", full, 1);
    chk("t2_ovf", ovf, 1);
    chk("t2_done", done_cnt - db, 1);
    chk("t2_err", last_err, 0);
    chk("t2_wptr_gray", wptr_gray, 5'b11000);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    chk("t2_ovf_clr", ovf, 0);

    // ---- 3: timeout after a half-word
    do_reset();
    wb = aw_log.size(); db = done_cnt;
    send_cmd(8'd3);
    send_beats(33, 3);
    repeat (64) step();
    chk("t3_done_early", done, 0);
    step();
    chk("t3_done", done, 1);
    chk("t3_err", err, 1);
    step();
    chk("t3_cmd_rdy", cmd_rdy, 1);
    step();
    chk("t3_nwrites", aw_log.size() - wb, 1);
    chk("t3_dw0", dw_at(wb), 32'h4421);
    chk("t3_ndone", done_cnt - db, 1);

    // ---- 4: pointer wrap with the reader keeping pace
    do_reset();
    rptr_gray = 5'd0;
    wb = aw_log.size(); db = done_cnt; fb = full_cnt;
    send_cmd(8'd40);
    for (int i = 0; i < 40; i++) begin
      beat_vld  = 1'b1;
      beat_data = 9'(2 * i);
      step();
      beat_data = 9'(2 * i + 1);
      step();
      rptr_gray = gray5(i);
    end
    beat_vld = 1'b0;
    step(); step(); step();
    rptr_gray = gray5(40);
    chk("t4_nwrites", aw_log.size() - wb, 40);
    for (int i = 0; i < 40; i++) chk("t4_aw", aw_at(wb + i), i % 16);
    chk("t4_dw39", dw_at(wb + 39), {14'd0, 9'd79, 9'd78});
    chk("t4_full_seen", full_cnt - fb, 0);
    chk("t4_wptr_gray", wptr_gray, 5'b01100);
    chk("t4_ovf", ovf, 0);
    chk("t4_done", done_cnt - db, 1);

    // ---- 5: stray beat in IDLE, zero-length command, set-wins-over-clear
    do_reset();
    rptr_gray = 5'd0;
    wb = aw_log.size(); db = done_cnt;
    send_beats(5, 1);
    chk("t5_stray", stray, 1);
    send_cmd(8'd0);
    chk("t5_cmd_rdy", cmd_rdy, 1);
    step(); step();
    chk("t5_nwrites", aw_log.size() - wb, 0);
    chk("t5_ndone", done_cnt - db, 0);
    flag_clr = 1'b1;
    beat_vld = 1'b1;
    step();
    beat_vld = 1'b0;
    flag_clr = 1'b0;
    chk("t5_set_wins", stray, 1);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    chk("t5_stray_clr", stray, 0);

    // ---- 6: reset in the middle of a burst
    wb = aw_log.size(); db = done_cnt;
    send_cmd(8'd4);
    send_beats(119, 1);
    rstnw = 1'b1;
    step();
    chk("t6_cmd_rdy", cmd_rdy, 1);
    chk("t6_done", done, 0);
    chk("t6_cew", cew, 0);
    rstnw = 1'b0;
    send_cmd(8'd1);
    send_beats(85, 1);
    send_beats(102, 1);
    step(); step(); step();
    chk("t6_nwrites", aw_log.size() - wb, 1);
    chk("t6_dw0", dw_at(wb), 32'hCC55);
    chk("t6_aw0", aw_at(wb), 0);
    chk("t6_ndone", done_cnt - db, 1);
    chk("t6_err", last_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
